// File: rtl/t01_ai_pkg.sv
// rtl/t01_ai_pkg.sv - shared types, layer geometry and requantization for the AI layer sequencer
package t01_ai_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    FEED,
    COLLECT,
    OUT
  } state_t;

  localparam int         ACT_MAX    = 127;
  localparam logic [1:0] LAST_LAYER = 2'd3;

  // Number of activations streamed into the MMU for a layer
  function automatic logic [5:0] layer_n_in(input logic [1:0] layer);
    return (layer == 2'd0) ? 6'd4 : 6'd32;
  endfunction

  // Number of results the MMU returns for a layer
  function automatic logic [5:0] layer_m_out(input logic [1:0] layer);
    return (layer == LAST_LAYER) ? 6'd1 : 6'd32;
  endfunction

  // ReLU output is non-negative, so a logical shift plus upper clamp is enough
  function automatic logic [7:0] requant(input logic [17:0] res, input int sh);
    logic [17:0] q;
    q = res >> sh;
    return (q > 18'(ACT_MAX)) ? 8'(ACT_MAX) : q[7:0];
  endfunction

endpackage

// File: rtl/t01_ai_act_buf.sv
// rtl/t01_ai_act_buf.sv - ping-pong activation buffer, 2 banks of 32 x 8-bit entries
module t01_ai_act_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [31:0] load_data,
  input  logic       swap,
  input  logic       wr_en,
  input  logic [4:0] wr_idx,
  input  logic [7:0] wr_data,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_data
);

  logic [7:0] bank [2][32];
  logic       sel;

  // Reads come from the current bank, writes land in the other one
  assign rd_data = bank[sel][rd_idx];

  // Load clears both banks and seeds the read bank; swap flips roles after the final write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 32; i++)
          bank[b][i] <= 8'd0;
    end else if (load) begin
      sel <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 32; i++)
          bank[b][i] <= 8'd0;
      for (int i = 0; i < 4; i++)
        bank[0][i] <= load_data[8*i +: 8];
    end else begin
      if (wr_en)
        bank[~sel][wr_idx] <= wr_data;
      if (swap)
        sel <= ~sel;
    end
  end

endmodule

// File: rtl/t01_ai_layer_seq.sv
// rtl/t01_ai_layer_seq.sv - runs one board vector through MMU layers 0-3 and returns the score
module t01_ai_layer_seq
  import t01_ai_pkg::*;
#(
  parameter int SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_feat,
  output logic        mmu_start,
  output logic [1:0]  mmu_layer_sel,
  output logic        mmu_act_valid,
  output logic [7:0]  mmu_act_in,
  input  logic        mmu_res_valid,
  input  logic [17:0] mmu_res_out,
  input  logic        mmu_done,
  output logic        score_valid,
  output logic [17:0] score,
  output logic        err
);

  state_t      state, state_d;
  logic [5:0]  cnt, cnt_d;
  logic [1:0]  layer_d;
  logic        start_d, act_valid_d, score_valid_d, err_d;
  logic [7:0]  act_in_d;
  logic [17:0] score_d;
  logic [5:0]  n_in, m_out;
  logic [6:0]  res_total;
  logic        buf_load, buf_swap, wr_en;
  logic [7:0]  rd_data;

  assign in_ready = (state == IDLE);

  t01_ai_act_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_data (in_feat),
    .swap      (buf_swap),
    .wr_en     (wr_en),
    .wr_idx    (cnt[4:0]),
    .wr_data   (requant(mmu_res_out, SHIFT)),
    .rd_idx    (cnt[4:0]),
    .rd_data   (rd_data)
  );

  // Next state plus next values of every registered output; cnt is feed index or result count
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    layer_d       = mmu_layer_sel;
    start_d       = 1'b0;
    act_valid_d   = 1'b0;
    act_in_d      = 8'd0;
    score_d       = score;
    score_valid_d = 1'b0;
    err_d         = err;
    buf_load      = 1'b0;
    buf_swap      = 1'b0;
    wr_en         = 1'b0;
    n_in          = layer_n_in(mmu_layer_sel);
    m_out         = layer_m_out(mmu_layer_sel);
    res_total     = {1'b0, cnt} + {6'd0, mmu_res_valid};
    case (state)
      IDLE: begin
        if (in_valid) begin
          buf_load = 1'b1;
          layer_d  = 2'd0;
          err_d    = 1'b0;
          cnt_d    = 6'd0;
          start_d  = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        act_valid_d = 1'b1;
        act_in_d    = rd_data;
        cnt_d       = 6'd1;
        state_d     = FEED;
      end
      FEED: begin
        if (cnt == n_in) begin
          cnt_d   = 6'd0;
          state_d = COLLECT;
        end else begin
          act_valid_d = 1'b1;
          act_in_d    = rd_data;
          cnt_d       = cnt + 6'd1;
        end
      end
      COLLECT: begin
        if (mmu_res_valid) begin
          wr_en = 1'b1;
          if (cnt != 6'd63)
            cnt_d = cnt + 6'd1;
        end
        if (mmu_done) begin
          if (res_total != {1'b0, m_out})
            err_d = 1'b1;
          cnt_d = 6'd0;
          if (mmu_layer_sel == LAST_LAYER) begin
            score_d       = mmu_res_out;
            score_valid_d = 1'b1;
            state_d       = OUT;
          end else begin
            buf_swap = 1'b1;
            layer_d  = mmu_layer_sel + 2'd1;
            start_d  = 1'b1;
            state_d  = START;
          end
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 6'd0;
      mmu_layer_sel <= 2'd0;
      mmu_start     <= 1'b0;
      mmu_act_valid <= 1'b0;
      mmu_act_in    <= 8'd0;
      score         <= 18'd0;
      score_valid   <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      mmu_layer_sel <= layer_d;
      mmu_start     <= start_d;
      mmu_act_valid <= act_valid_d;
      mmu_act_in    <= act_in_d;
      score         <= score_d;
      score_valid   <= score_valid_d;
      err           <= err_d;
    end
  end

endmodule
